store_align: RTL and testbench
==============================

STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port req_valid  input  1  store request present.
REQ-004 SHALL have port req_ready  output  1  block can accept a request.
REQ-005 SHALL have port req_addr  input  32  byte address of store.
REQ-006 SHALL have port req_data  input  32  store data, right-justified in low bits.
REQ-007 SHALL have port req_size  input  2  SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2; 3 illegal.
REQ-008 SHALL have port mem_valid  output  1  bus write beat valid.
REQ-009 SHALL have port mem_ready  input  1  bus accepts beat.
REQ-010 SHALL have port mem_addr  output  32  word-aligned beat address, bits[1:0]=0.
REQ-011 SHALL have port mem_wdata  output  32  lane-positioned write data.
REQ-012 SHALL have port mem_wstrb  output  4  byte-lane write enables.
REQ-013 SHALL have port done  output  1  one-cycle pulse, store complete.
REQ-014 SHALL have port err  output  1  one-cycle pulse, illegal size rejected.

Function
REQ-015 SHALL implement FSM states IDLE, BEAT0, BEAT1.
REQ-016 SHALL assert req_ready only in IDLE; request accepted when req_valid && req_ready.
REQ-017 SHALL on acceptance register addr, size, and data masked to size (byte: [7:0], half: [15:0], word: all).
REQ-018 SHALL form 64-bit lane data = masked data << (8*addr[1:0]) and 8-bit strobe = (1/3/F for byte/half/word) << addr[1:0].
REQ-019 SHALL on legal acceptance go IDLE->BEAT0; mem_valid asserts in the next cycle (1-cycle latency).
REQ-020 SHALL in BEAT0 drive mem_addr={addr[31:2],2'b00}, mem_wdata=lane[31:0], mem_wstrb=strobe[3:0].
REQ-021 SHALL on BEAT0 handshake go to BEAT1 if strobe[7:4]!=0, else to IDLE.
REQ-022 SHALL in BEAT1 drive mem_addr={addr[31:2],2'b00}+4 (mod 2^32), mem_wdata=lane[63:32], mem_wstrb=strobe[7:4]; on handshake go IDLE.
REQ-023 SHALL hold mem_valid, mem_addr, mem_wdata, mem_wstrb stable while mem_valid && !mem_ready.
REQ-024 SHALL drive mem_wdata, mem_wstrb, mem_addr to 0 when mem_valid=0.
REQ-025 SHALL pulse done in the cycle after the final beat handshake; req_ready is high in that cycle.
REQ-026 SHALL on illegal size accept the request, issue no beat, stay IDLE, and pulse err the next cycle.
REQ-027 SHALL ignore req_* inputs while not in IDLE.
REQ-028 SHALL wrap the BEAT1 address from 0xFFFFFFFC to 0x00000000.

Reset
REQ-029 SHALL on rst_n low immediately force IDLE, mem_valid=0, done=0, err=0, req_ready=0, registered addr/data/size=0.
REQ-030 SHALL drive req_ready=1 from the first cycle after rst_n deasserts.
REQ-031 SHALL abort any in-flight store on reset with no done pulse and no resumed beat.

Structure
REQ-032 SHALL take SZ_BYTE/SZ_HALF/SZ_WORD constants and the FSM state enum from the shared core signals package.
REQ-033 SHALL implement lane/strobe generation (REQ-018) as combinational sub-module store_lane_gen; FSM and registers stay in store_align.

Verification
REQ-034 SHALL cover word store addr=0x1000, data=0xDEADBEEF, mem_ready=1 -> one beat addr 0x1000, wdata 0xDEADBEEF, wstrb 0xF, done next cycle.
REQ-035 SHALL cover byte store addr=0x1003, data=0x123456AB -> one beat addr 0x1000, wdata 0xAB000000, wstrb 0x8.
REQ-036 SHALL cover misaligned word addr=0x2001, data=0x11223344 -> beat addr 0x2000 wdata 0x22334400 wstrb 0xE, then addr 0x2004 wdata 0x00000011 wstrb 0x1.
REQ-037 SHALL cover half store addr=0xFFFFFFFF, data=0xBEEF, mem_ready stalled 3 cycles per beat -> beat addr 0xFFFFFFFC wdata 0xEF000000 wstrb 0x8 held stable, then addr 0x00000000 wdata 0x000000BE wstrb 0x1.
REQ-038 SHALL cover req_size=3 -> no mem_valid, err pulse one cycle after acceptance, req_ready stays 1.
REQ-039 SHALL cover rst_n low during BEAT1 stall -> mem_valid drops immediately, no done, next store after reset completes normally.

Source files
------------

// File: rtl/store_align_pkg.sv
// Shared definitions for the store aligner: access-size encodings, the FSM
// state type and the size-based data mask.
package store_align_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  // Clears any store data bits above the access size.
  function automatic logic [31:0] mask_data(input logic [31:0] data,
                                            input logic [1:0]  size);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = {24'd0, data[7:0]};
      SZ_HALF: res = {16'd0, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Places right-justified store data and its byte strobes onto a two-word
// (64-bit) lane window starting at the byte offset within the first word.
module store_lane_gen
  import store_align_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [63:0] lane,
  output logic [7:0]  strobe
);

  logic [3:0] base_strb;

  always_comb begin
    case (size)
      SZ_BYTE: base_strb = 4'h1;
      SZ_HALF: base_strb = 4'h3;
      SZ_WORD: base_strb = 4'hF;
      default: base_strb = 4'h0;
    endcase
    lane   = {32'd0, data} << {offset, 3'b000};
    strobe = {4'd0, base_strb} << offset;
  end

endmodule

// File: rtl/store_align.sv
// Converts a byte/half/word store at any byte address into one or two
// word-aligned bus write beats with lane-positioned data and strobes.
module store_align
  import store_align_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [63:0] lane;
  logic [7:0]  strobe;
  logic [31:0] beat_base;

  store_lane_gen u_lane_gen (
    .offset (addr_q[1:0]),
    .size   (size_q),
    .data   (data_q),
    .lane   (lane),
    .strobe (strobe)
  );

  assign beat_base = {addr_q[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // ready_q is only ever high in IDLE, so it doubles as the accept gate
        if (req_valid && ready_q) begin
          addr_d = req_addr;
          size_d = req_size;
          data_d = mask_data(req_data, req_size);
          if (req_size == SZ_ILL) err_d = 1'b1;
          else                    state_d = BEAT0;
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (strobe[7:4] != 4'h0) begin
            state_d = BEAT1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Beat outputs decode straight from held registers, so they stay stable
  // through a stall and read as zero whenever no beat is offered.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state_q)
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = beat_base;
        mem_wdata = lane[31:0];
        mem_wstrb = strobe[3:0];
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = beat_base + 32'd4;
        mem_wdata = lane[63:32];
        mem_wstrb = strobe[7:4];
      end
      default: ;
    endcase
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: expected bus beats are queued when a store
// is issued and compared by a monitor as each beat handshakes.
module tb_store_align;
  import store_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    stall_n = 0;
  int    stall_cnt = 0;

  store_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic last);
    beat_t b;
    b.addr = a; b.wdata = d; b.wstrb = s; b.last = last;
    sb.push_back(b);
  endtask

  // Byte-by-byte reference: each byte lands in whichever aligned word holds its address.
  task automatic model_push(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    beat_t       b0, b1;
    logic [31:0] w0, a;
    int          nb, ln;
    w0 = {addr[31:2], 2'b00};
    b0 = '0; b1 = '0;
    b0.addr = w0; b1.addr = w0 + 32'd4;
    nb = (size == SZ_BYTE) ? 1 : (size == SZ_HALF) ? 2 : 4;
    for (int i = 0; i < nb; i++) begin
      a  = addr + i;
      ln = int'(a[1:0]);
      if ({a[31:2], 2'b00} == w0) begin
        b0.wdata[8*ln +: 8] = data[8*i +: 8];
        b0.wstrb[ln] = 1'b1;
      end else begin
        b1.wdata[8*ln +: 8] = data[8*i +: 8];
        b1.wstrb[ln] = 1'b1;
      end
    end
    if (b1.wstrb != 4'h0) begin
      b1.last = 1'b1; sb.push_back(b0); sb.push_back(b1);
    end else begin
      b0.last = 1'b1; sb.push_back(b0);
    end
  endtask

  // Bus-side responder: holds mem_ready low for stall_n cycles of each beat.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_valid) begin
        if (stall_cnt < stall_n) begin mem_ready = 1'b0; stall_cnt++; end
        else begin mem_ready = 1'b1; stall_cnt = 0; end
      end else begin
        mem_ready = (stall_n == 0);
        stall_cnt = 0;
      end
    end
  end

  // Monitor: beat compare, stall stability, idle-zero bus and done timing.
  initial begin
    logic        exp_done, prev_stall;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    beat_t       e;
    exp_done = 1'b0; prev_stall = 1'b0;
    p_addr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_done = 1'b0; prev_stall = 1'b0;
      end else begin
        check("done_pulse", done, exp_done);
        exp_done = 1'b0;
        if (prev_stall) begin
          check("hold_valid", mem_valid, 1);
          check("hold_addr", mem_addr, p_addr);
          check("hold_wdata", mem_wdata, p_wdata);
          check("hold_wstrb", mem_wstrb, p_wstrb);
        end
        if (!mem_valid)
          check("idle_bus_zero", mem_addr | mem_wdata | {28'd0, mem_wstrb}, 0);
        if (mem_valid && mem_ready) begin
          check("beat_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat_addr", mem_addr, e.addr);
            check("beat_wdata", mem_wdata, e.wdata);
            check("beat_wstrb", mem_wstrb, e.wstrb);
            exp_done = e.last;
          end
        end
        prev_stall = mem_valid && !mem_ready;
        p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("ready_wait", req_ready, 1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    wait_ready();
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
    @(posedge clk); #1;
    check("beat_latency", mem_valid, 32'(sz != SZ_ILL));
    check("err_pulse", err, 32'(sz == SZ_ILL));
    if (sz != SZ_ILL) begin
      // a request presented while busy must be ignored
      req_addr = 32'h0BAD_0000; req_data = 32'hFFFF_FFFF; req_size = SZ_WORD;
      check("ready_low_busy", req_ready, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 200) begin @(posedge clk); #1; n++; end
    check("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_ready", req_ready, 0);
    check("rst_valid", mem_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", req_ready, 1);

    // aligned word
    push_beat(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1);
    issue(32'h0000_1000, 32'hDEAD_BEEF, SZ_WORD);
    wait_idle();

    // byte in top lane, upper data bits must be masked
    push_beat(32'h0000_1000, 32'hAB00_0000, 4'h8, 1'b1);
    issue(32'h0000_1003, 32'h1234_56AB, SZ_BYTE);
    wait_idle();

    // misaligned word split over two beats
    push_beat(32'h0000_2000, 32'h2233_4400, 4'hE, 1'b0);
    push_beat(32'h0000_2004, 32'h0000_0011, 4'h1, 1'b1);
    issue(32'h0000_2001, 32'h1122_3344, SZ_WORD);
    wait_idle();

    // half crossing the top of the address space with stalls
    stall_n = 3;
    push_beat(32'hFFFF_FFFC, 32'hEF00_0000, 4'h8, 1'b0);
    push_beat(32'h0000_0000, 32'h0000_00BE, 4'h1, 1'b1);
    issue(32'hFFFF_FFFF, 32'h0000_BEEF, SZ_HALF);
    wait_idle();
    stall_n = 0;

    // illegal size
    issue(32'h0000_5000, 32'h0000_0055, SZ_ILL);
    check("ill_ready", req_ready, 1);
    @(posedge clk); #1;
    check("ill_err_clear", err, 0);
    check("ill_no_beat", mem_valid, 0);

    // reference-model stores, one-cycle stalls
    stall_n = 1;
    model_push(32'h0000_4002, 32'hA1B2_C3D4, SZ_WORD); issue(32'h0000_4002, 32'hA1B2_C3D4, SZ_WORD); wait_idle();
    model_push(32'h0000_4001, 32'h7777_5A6B, SZ_HALF); issue(32'h0000_4001, 32'h7777_5A6B, SZ_HALF); wait_idle();
    model_push(32'h0000_4003, 32'h0000_C001, SZ_HALF); issue(32'h0000_4003, 32'h0000_C001, SZ_HALF); wait_idle();
    model_push(32'h0000_4002, 32'hFFFF_FF3C, SZ_BYTE); issue(32'h0000_4002, 32'hFFFF_FF3C, SZ_BYTE); wait_idle();
    model_push(32'h0000_4003, 32'h0102_0304, SZ_WORD); issue(32'h0000_4003, 32'h0102_0304, SZ_WORD); wait_idle();

    // reset during a stalled second beat
    stall_n = 10;
    push_beat(32'h0000_3000, 32'hFE00_0000, 4'h8, 1'b0);
    push_beat(32'h0000_3004, 32'h0000_00CA, 4'h1, 1'b1);
    issue(32'h0000_3003, 32'h0000_CAFE, SZ_HALF);
    n = 0;
    while (!(mem_valid && mem_addr == 32'h0000_3004) && n < 100) begin @(posedge clk); #1; n++; end
    check("reach_beat1", mem_addr, 32'h0000_3004);
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_valid", mem_valid, 0);
    check("abort_ready", req_ready, 0);
    check("abort_addr", mem_addr, 0);
    stall_n = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_resume", mem_valid, 0);
      check("no_done", done, 0);
    end
    push_beat(32'h0000_6000, 32'h0BAD_F00D, 4'hF, 1'b1);
    issue(32'h0000_6000, 32'h0BAD_F00D, SZ_WORD);
    wait_idle();
    repeat (2) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
